// File: rtl/mem_if.sv
// Sigmoid ROM read bus: read enable, Q4.4 argument, Q8.24 result.
interface mem_if;
   logic        din;
   logic [7:0]  addr;
   logic [31:0] dout;

   modport master (output din, output addr, input dout);
   modport slave  (input din, input addr, output dout);
endinterface

// File: rtl/mem.sv
// Read-only sigmoid lookup: dout <= round(2^24 / (1 + e^(-addr/16))), addr signed Q4.4.
// One-cycle read latency, hold when din=0, asynchronous active-low clear.
// Optional MEM_SYMMETRY_EN: store magnitudes 0..128 only and rebuild negative
// arguments as 2^24 - T(|a|); output is bit-identical to the full table.
module mem (
   input logic clk,
   input logic rst_n,
   mem_if.slave bus
);

   // Elaboration-time sigmoid for a non-negative argument m/16, Q8.24, rounded to nearest.
   // Negative arguments are always derived as 2^24 - sig_pos(|a|) (sigmoid(-x) = 1 - sigmoid(x)),
   // so both build options share one rounding path and agree bit for bit.
   function automatic int unsigned sig_pos(input int unsigned m);
      real x;
      real term;
      real e;
      x    = $itor(m) / 16.0;
      term = 1.0;
      e    = 1.0;
      for (int unsigned k = 1; k < 64; k++) begin
         term = term * x / $itor(k);
         e    = e + term;
      end
      return $rtoi(16777216.0 * e / (e + 1.0) + 0.5);
   endfunction

   logic [23:0] val;
   logic [23:0] dout_d;
   logic [23:0] dout_q;

`ifdef MEM_SYMMETRY_EN
   logic [23:0] rom_mag [129];
   logic [7:0]  mag;
   logic [23:0] entry;

   for (genvar g = 0; g < 129; g++) begin : g_rom
      localparam int unsigned V = sig_pos(g);
      assign rom_mag[g] = V[23:0];
   end

   // Fold the signed argument to its magnitude; negative side is 2^24 - T(|a|),
   // which in 24-bit arithmetic is the two's complement of the stored entry.
   always_comb begin
      mag   = bus.addr[7] ? 8'('0 - bus.addr) : bus.addr;
      entry = rom_mag[mag];
      val   = bus.addr[7] ? 24'('0 - entry) : entry;
   end
`else
   localparam int unsigned ONE_Q24 = 32'd16777216;

   logic [23:0] rom [256];

   for (genvar g = 0; g < 256; g++) begin : g_rom
      localparam int unsigned V = (g < 128) ? sig_pos(g) : ONE_Q24 - sig_pos(256 - g);
      assign rom[g] = V[23:0];
   end

   // Direct lookup over all 256 signed arguments.
   always_comb begin
      val = rom[bus.addr];
   end
`endif

   // Load a new table value on read enable, otherwise hold.
   always_comb begin
      dout_d = bus.din ? val : dout_q;
   end

   // Output register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout_q <= '0;
      else        dout_q <= dout_d;
   end

   assign bus.dout = {8'h00, dout_q};

endmodule

// File: tb/tb_mem.sv
// Self-checking bench for the sigmoid ROM: fixed vectors, hold, mid-cycle address
// change, asynchronous reset, and a full signed sweep against a real-valued model.
module tb_mem;

   logic clk;
   logic rst_n;

   mem_if bus ();

   mem u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] exp;
   } vec_t;

   vec_t          vecs [14];
   logic [31:0]   exp_q [$];
   int            tests = 0;
   int            fails = 0;
   logic [31:0]   prev;
   logic [31:0]   min_v;

   // Independent reference: round-to-nearest of 2^24 / (1 + e^(-a/16)).
   function automatic logic [31:0] model_t(input logic [7:0] a);
      int  s;
      real v;
      s = int'($signed(a));
      v = 16777216.0 / (1.0 + $exp(-$itor(s) / 16.0));
      return 32'($rtoi(v + 0.5));
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: dout=%h expected=%h", nm, act, exp);
      end
   endtask

   // Drive one cycle at the falling edge, queue its expectation, compare after the rising edge.
   task automatic step(input logic d, input logic [7:0] a, input logic [31:0] exp, input string nm);
      @(negedge clk);
      bus.din  = d;
      bus.addr = a;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s: scoreboard empty, dout=%h expected=none", nm, bus.dout);
      end else begin
         check(nm, bus.dout, exp_q.pop_front());
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, dout=%h expected=finish", bus.dout);
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{8'h2F, 32'h00F31D88};
      vecs[1]  = '{8'h56, 32'h00FED1E8};
      vecs[2]  = '{8'h49, 32'h00FD5B22};
      vecs[3]  = '{8'h1C, 32'h00DA1994};
      vecs[4]  = '{8'h3E, 32'h00FACB80};
      vecs[5]  = '{8'h44, 32'h00FC6653};
      vecs[6]  = '{8'h2B, 32'h00EFB060};
      vecs[7]  = '{8'h47, 32'h00FD0210};
      vecs[8]  = '{8'h2C, 32'h00F09E29};
      vecs[9]  = '{8'h17, 32'h00CEDD7E};
      vecs[10] = '{8'h27, 32'h00EB6DB1};
      vecs[11] = '{8'h2F, 32'h00F31D88};
      vecs[12] = '{8'hD1, 32'h000CE278};
      vecs[13] = '{8'h00, 32'h00800000};

      // Reset: output clear before any clock edge and while clocks run in reset.
      rst_n    = 1'b0;
      bus.din  = 1'b1;
      bus.addr = 8'h2F;
      #2;
      check("reset_async", bus.dout, 32'h0);
      @(posedge clk);
      #1;
      check("reset_held", bus.dout, 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 8'h00, 32'h00800000, "zero_arg");

      // Fixed vectors, one per cycle.
      foreach (vecs[i]) begin
         step(1'b1, vecs[i].addr, vecs[i].exp, $sformatf("vec_%0h", vecs[i].addr));
      end

      // Minimum at -128, strictly below -127.
      step(1'b1, 8'h80, model_t(8'h80), "min_0x80");
      min_v = bus.dout;
      step(1'b1, 8'h81, model_t(8'h81), "arg_0x81");
      tests++;
      if (!(min_v < bus.dout)) begin
         fails++;
         $display("FAIL min_below_0x81: dout(0x80)=%h dout(0x81)=%h", min_v, bus.dout);
      end
      step(1'b1, 8'h7F, model_t(8'h7F), "max_0x7F");

      // Hold with din=0 while addr moves, then resume.
      step(1'b1, 8'h1C, 32'h00DA1994, "hold_load");
      step(1'b0, 8'h56, 32'h00DA1994, "hold_1");
      step(1'b0, 8'h80, 32'h00DA1994, "hold_2");
      step(1'b0, 8'h7F, 32'h00DA1994, "hold_3");
      step(1'b1, 8'h56, 32'h00FED1E8, "hold_resume");

      // Mid-cycle addr change must not disturb the registered value.
      step(1'b1, 8'h3E, 32'h00FACB80, "midcyc_load");
      #2;
      bus.addr = 8'h17;
      #1;
      check("midcyc_stable", bus.dout, 32'h00FACB80);
      step(1'b1, 8'h17, 32'h00CEDD7E, "midcyc_next");

      // Asynchronous reset between edges, no late update, clean restart.
      step(1'b1, 8'h2F, 32'h00F31D88, "arst_pre");
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_immediate", bus.dout, 32'h0);
      @(posedge clk);
      #1;
      check("arst_no_late", bus.dout, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 8'h44, 32'h00FC6653, "arst_restart");

      // Full signed sweep: model match, upper byte zero, monotonic non-decreasing.
      for (int i = -128; i < 128; i++) begin
         logic [7:0] a;
         a = 8'(i);
         step(1'b1, a, model_t(a), $sformatf("sweep_%0h", a));
         if (i > -128) begin
            tests++;
            if (bus.dout < prev) begin
               fails++;
               $display("FAIL monotonic_%0h: dout=%h previous=%h", a, bus.dout, prev);
            end
         end
         prev = bus.dout;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
